// File: rtl/dictionary_cam.sv
// dictionary_cam: loadable key/value dictionary for field compression.
// Serves key->value and value->key lookups with saturating statistics.
module dictionary_cam #(
  parameter int KEY_WIDTH = 5,
  parameter int VAL_WIDTH = 10,
  parameter int DEPTH     = 2**KEY_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [VAL_WIDTH-1:0] load_val,
  output logic                 load_ready,
  input  logic                 load_done,
  output logic [KEY_WIDTH:0]   load_count,
  output logic                 full,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_mode,
  input  logic [KEY_WIDTH-1:0] req_key,
  input  logic [VAL_WIDTH-1:0] req_val,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [KEY_WIDTH-1:0] resp_key,
  output logic [VAL_WIDTH-1:0] resp_val,
  output logic [CNT_WIDTH-1:0] lookup_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  typedef enum logic {
    SERVE,
    LOAD
  } state_t;

  localparam logic [KEY_WIDTH:0] DEPTH_C =
    (KEY_WIDTH+1)'(DEPTH);

  state_t state_q, state_d;

  logic [VAL_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [KEY_WIDTH:0]   count_q;

  logic                 clr;
  logic                 load_fire;
  logic                 req_fire;
  logic                 d_hit;
  logic [VAL_WIDTH-1:0] d_val;
  logic                 c_hit;
  logic [KEY_WIDTH-1:0] c_key;
  logic                 lk_hit;

  assign load_count = count_q;
  assign full       = (count_q == DEPTH_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SERVE;
    else       state_q <= state_d;
  end

  // load_start wins over load_done and over a coincident load word
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    req_ready  = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      SERVE: begin
        req_ready = !resp_valid || resp_ready;
        if (load_start) begin
          clr     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_ready = !full;
        if (load_start)     clr     = 1'b1;
        else if (load_done) state_d = SERVE;
      end
      default: state_d = SERVE;
    endcase
  end

  assign load_fire = load_valid && load_ready && !clr;
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    d_hit = ({1'b0, req_key} < count_q);
    d_val = '0;
    if (d_hit) d_val = mem[req_key];
  end

  // lowest matching valid index wins
  always_comb begin
    c_hit = 1'b0;
    c_key = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!c_hit && valid_q[i] && mem[i] == req_val) begin
        c_hit = 1'b1;
        c_key = KEY_WIDTH'(i);
      end
    end
  end

  assign lk_hit = req_mode ? c_hit : d_hit;

  always_ff @(posedge clk) begin
    if (load_fire) mem[count_q[KEY_WIDTH-1:0]] <= load_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (load_fire) begin
      valid_q[count_q[KEY_WIDTH-1:0]] <= 1'b1;
      count_q <= count_q + (KEY_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_key   <= '0;
      resp_val   <= '0;
    end else if (req_fire) begin
      resp_valid <= 1'b1;
      resp_hit   <= lk_hit;
      unique case (req_mode)
        1'b0: begin
          resp_key <= '0;
          resp_val <= d_val;
        end
        1'b1: begin
          resp_key <= c_key;
          resp_val <= req_val;
        end
        default: begin
          resp_key <= '0;
          resp_val <= '0;
        end
      endcase
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookup_cnt <= '0;
      miss_cnt   <= '0;
    end else if (clr) begin
      lookup_cnt <= '0;
      miss_cnt   <= '0;
    end else if (req_fire) begin
      if (lookup_cnt != '1)
        lookup_cnt <= lookup_cnt + CNT_WIDTH'(1);
      if (!lk_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dictionary_cam.sv
// tb_dictionary_cam: vector table plus scoreboard for dictionary_cam.
// Covers load, lookups, back-pressure, reload and async reset.
module tb_dictionary_cam;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [9:0] load_val;
  logic       load_ready;
  logic       load_done;
  logic [5:0] load_count;
  logic       full;
  logic       req_valid;
  logic       req_ready;
  logic       req_mode;
  logic [4:0] req_key;
  logic [9:0] req_val;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_hit;
  logic [4:0] resp_key;
  logic [9:0] resp_val;
  logic [15:0] lookup_cnt;
  logic [15:0] miss_cnt;

  dictionary_cam dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_val   (load_val),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .full       (full),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_key    (req_key),
    .req_val    (req_val),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_key   (resp_key),
    .resp_val   (resp_val),
    .lookup_cnt (lookup_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       hit;
    logic [4:0] key;
    logic [9:0] val;
  } rsp_t;

  typedef struct {
    logic       mode;
    logic [4:0] key;
    logic [9:0] val;
    rsp_t       exp;
  } vec_t;

  rsp_t sb[$];
  rsp_t exp_next;
  vec_t vt[8];

  int total;
  int bad;
  int n_resp;
  logic fired;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " load_count"}, 32'(load_count), 32'd0);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " load_ready"}, 32'(load_ready), 32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_hit"}, 32'(resp_hit), 32'd0);
    chk({tag, " resp_key"}, 32'(resp_key), 32'd0);
    chk({tag, " resp_val"}, 32'(resp_val), 32'd0);
    chk({tag, " lookup_cnt"}, 32'(lookup_cnt), 32'd0);
    chk({tag, " miss_cnt"}, 32'(miss_cnt), 32'd0);
  endtask

  // one clock: score handshakes just before the edge, then step past it
  task automatic cyc();
    logic stall;
    rsp_t held;
    rsp_t e;
    #1;
    fired = 1'b0;
    if (resp_valid && resp_ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_hit", 32'(resp_hit), 32'(e.hit));
        chk("resp_key", 32'(resp_key), 32'(e.key));
        chk("resp_val", 32'(resp_val), 32'(e.val));
      end
    end
    if (req_valid && req_ready) begin
      fired = 1'b1;
      sb.push_back(exp_next);
    end
    stall = resp_valid && !resp_ready;
    held  = '{resp_hit, resp_key, resp_val};
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_fields",
          32'({resp_hit, resp_key, resp_val}), 32'(held));
    end
  endtask

  task automatic issue(input logic m, input logic [4:0] k,
                       input logic [9:0] v, input rsp_t e);
    req_valid = 1'b1;
    req_mode  = m;
    req_key   = k;
    req_val   = v;
    exp_next  = e;
    fired     = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) cyc();
    if (!fired) chk("req_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int j;
    int base;
    rsp_t e;
    total = 0;
    bad   = 0;
    n_resp = 0;

    vt[0] = '{1'b1, 5'd0,  10'h3A5, '{1'b1, 5'd0, 10'h3A5}};
    vt[1] = '{1'b1, 5'd0,  10'h1FF, '{1'b0, 5'd0, 10'h1FF}};
    vt[2] = '{1'b0, 5'd3,  10'h000, '{1'b1, 5'd0, 10'h200}};
    vt[3] = '{1'b0, 5'd4,  10'h000, '{1'b0, 5'd0, 10'h000}};
    vt[4] = '{1'b1, 5'd0,  10'h200, '{1'b1, 5'd3, 10'h200}};
    vt[5] = '{1'b1, 5'd0,  10'h001, '{1'b1, 5'd1, 10'h001}};
    vt[6] = '{1'b0, 5'd0,  10'h000, '{1'b1, 5'd0, 10'h3A5}};
    vt[7] = '{1'b0, 5'd31, 10'h000, '{1'b0, 5'd0, 10'h000}};

    reset      = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_val   = '0;
    load_done  = 1'b0;
    req_valid  = 1'b0;
    req_mode   = 1'b0;
    req_key    = '0;
    req_val    = '0;
    resp_ready = 1'b1;
    exp_next   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    reset = 1'b0;

    // first dictionary: four words
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    chk("load req_ready", 32'(req_ready), 32'd0);
    chk("load load_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_val = 10'h3A5; cyc();
    load_val = 10'h001; cyc();
    load_val = 10'h3A5; cyc();
    load_val = 10'h200; cyc();
    load_valid = 1'b0;
    load_done  = 1'b1;
    cyc();
    load_done = 1'b0;
    chk("count4", 32'(load_count), 32'd4);
    chk("full4", 32'(full), 32'd0);
    chk("serve req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      issue(vt[i].mode, vt[i].key, vt[i].val, vt[i].exp);
      drain();
    end
    chk("tbl lookup_cnt", 32'(lookup_cnt), 32'd8);
    chk("tbl miss_cnt", 32'(miss_cnt), 32'd3);

    // fill all 32 entries, then offer a 33rd word
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      load_val = (i < 32) ? 10'(i * 3 + 1) : 10'h3FF;
      if (i == 31) chk("ready@31", 32'(load_ready), 32'd1);
      if (i == 32) begin
        chk("ready@full", 32'(load_ready), 32'd0);
        chk("full@32", 32'(full), 32'd1);
      end
      cyc();
    end
    load_valid = 1'b0;
    chk("count32", 32'(load_count), 32'd32);
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;

    // 10 streamed requests under 1,0 resp_ready pattern
    base = n_resp;
    j = 0;
    for (int c = 0; c < 200 && (j < 10 || sb.size() != 0); c++) begin
      resp_ready = (c % 2 == 0);
      req_valid  = (j < 10);
      if (j % 2 == 0) begin
        req_mode = 1'b0;
        req_key  = 5'(j);
        req_val  = '0;
        e = '{1'b1, 5'd0, 10'(j * 3 + 1)};
      end else if (j < 9) begin
        req_mode = 1'b1;
        req_key  = '0;
        req_val  = 10'(j * 3 + 1);
        e = '{1'b1, 5'(j), 10'(j * 3 + 1)};
      end else begin
        req_mode = 1'b1;
        req_key  = '0;
        req_val  = 10'h3FF;
        e = '{1'b0, 5'd0, 10'h3FF};
      end
      exp_next = e;
      cyc();
      if (fired) j++;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    chk("stream sent", 32'(j), 32'd10);
    chk("stream resps", 32'(n_resp - base), 32'd10);
    chk("stream lookup_cnt", 32'(lookup_cnt), 32'd10);
    chk("stream miss_cnt", 32'(miss_cnt), 32'd1);

    // pending response survives a reload start
    resp_ready = 1'b0;
    issue(1'b1, 5'd0, 10'd94, '{1'b1, 5'd31, 10'd94});
    chk("pend valid", 32'(resp_valid), 32'd1);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    chk("reload resp_valid", 32'(resp_valid), 32'd1);
    chk("reload req_ready", 32'(req_ready), 32'd0);
    chk("reload lookup_cnt", 32'(lookup_cnt), 32'd0);
    chk("reload miss_cnt", 32'(miss_cnt), 32'd0);
    chk("reload count", 32'(load_count), 32'd0);
    resp_ready = 1'b1;
    drain();
    chk("drained valid", 32'(resp_valid), 32'd0);

    // async reset after two words of a load
    load_valid = 1'b1;
    load_val = 10'h055; cyc();
    load_val = 10'h066; cyc();
    load_valid = 1'b0;
    chk("count2", 32'(load_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(1'b1, 5'd0, 10'h055, '{1'b0, 5'd0, 10'h055});
    drain();
    chk("post-reset miss_cnt", 32'(miss_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
